// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer: loads a packed BCD preset, decrements it once per
// prescaled tick with borrow ripple across digits, and pulses done on reaching zero.
module bcd_down_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  clear_,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_running;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;

  logic [CW-1:0] w_count_dec;
  logic          w_data_valid;
  logic          w_tick;

  assign w_tick = (r_presc == PRE_MAX);

  // Borrow starts at digit 0 and stops at the first non-zero digit.
  always_comb begin
    logic borrow;
    borrow      = 1'b1;
    w_count_dec = r_count;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_count_dec[4*i +: 4] = 4'd9;
        end else begin
          w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          borrow                = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_data_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (data[4*i +: 4] > 4'd9) begin
        w_data_valid = 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;

    if (load) begin
      if (w_data_valid) begin
        w_count_nxt = data;
        w_err_nxt   = 1'b0;
      end else begin
        w_err_nxt   = 1'b1;
      end
      w_state_nxt = ST_IDLE;
      w_presc_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_presc_nxt = '0;
            if (r_count != '0) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_EXPIRED;
              w_done_nxt  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            w_state_nxt = ST_PAUSED;
          end else if (w_tick) begin
            w_presc_nxt = '0;
            w_count_nxt = w_count_dec;
            if (w_count_dec == '0) begin
              w_state_nxt = ST_EXPIRED;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          w_count_nxt = '0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_) begin
    if (!clear_) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_presc   <= w_presc_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign count   = r_count;
  assign running = r_running;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed self-checking bench for bcd_down_counter: vector table plus hand-written
// sequences for countdown, borrow chain, pause and asynchronous reset.
module tb_bcd_down_counter;

  logic        clk;
  logic        clear_;
  logic        load_a, start_a, pause_a;
  logic [15:0] data_a;
  logic [15:0] count_a;
  logic        running_a, done_a, err_a;
  logic        load_b, start_b, pause_b;
  logic [15:0] data_b;
  logic [15:0] count_b;
  logic        running_b, done_b, err_b;

  int n_checks = 0;
  int n_errors = 0;

  bcd_down_counter #(.DIGITS(4), .PRESCALE(4)) u_dut_a (
    .clk     (clk),
    .clear_  (clear_),
    .load    (load_a),
    .data    (data_a),
    .start   (start_a),
    .pause   (pause_a),
    .count   (count_a),
    .running (running_a),
    .done    (done_a),
    .err     (err_a)
  );

  bcd_down_counter #(.DIGITS(4), .PRESCALE(1)) u_dut_b (
    .clk     (clk),
    .clear_  (clear_),
    .load    (load_b),
    .data    (data_b),
    .start   (start_b),
    .pause   (pause_b),
    .count   (count_b),
    .running (running_b),
    .done    (done_b),
    .err     (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [15:0] data;
    logic        start;
    logic        pause;
    logic [15:0] exp_count;
    logic        exp_running;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  initial begin
    clear_  = 1'b0;
    load_a  = 1'b0; start_a = 1'b0; pause_a = 1'b0; data_a = '0;
    load_b  = 1'b0; start_b = 1'b0; pause_b = 1'b0; data_b = '0;

    vecs[0]  = '{1'b1, 16'h00A5, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0003, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h9999, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h99A9, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    // Reset state while clear_ is held low across a clock edge.
    #12;
    chk("rst_count", 32'(count_a), 32'h0);
    chk("rst_running", 32'(running_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    chk("rst_count_b", 32'(count_b), 32'h0);
    clear_ = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      load_a  = vecs[i].load;
      data_a  = vecs[i].data;
      start_a = vecs[i].start;
      pause_a = vecs[i].pause;
      step();
      chk($sformatf("vec%0d_count", i), 32'(count_a), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_running", i), 32'(running_a), 32'(vecs[i].exp_running));
      chk($sformatf("vec%0d_done", i), 32'(done_a), 32'(vecs[i].exp_done));
      chk($sformatf("vec%0d_err", i), 32'(err_a), 32'(vecs[i].exp_err));
    end
    load_a = 1'b0; start_a = 1'b0; pause_a = 1'b0;

    // Full countdown from 12 with a tick every 4th cycle.
    load_a = 1'b1; data_a = 16'h0012;
    step();
    load_a = 1'b0; start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("cd_start_running", 32'(running_a), 32'h1);
    chk("cd_start_count", 32'(count_a), 32'h0012);
    for (int k = 1; k <= 48; k++) begin
      step();
      chk($sformatf("cd%0d_count", k), 32'(count_a), 32'(to_bcd(12 - k / 4)));
      chk($sformatf("cd%0d_done", k), 32'(done_a), 32'(k == 48));
      chk($sformatf("cd%0d_running", k), 32'(running_a), 32'(k < 48));
    end
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("cd_after_done", 32'(done_a), 32'h0);
    chk("cd_after_count", 32'(count_a), 32'h0);
    chk("cd_after_running", 32'(running_a), 32'h0);
    step();
    chk("cd_expired_done", 32'(done_a), 32'h0);

    // Pause mid-period with the prescaler frozen at 2.
    load_a = 1'b1; data_a = 16'h0005;
    step();
    load_a = 1'b0; start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    chk("pz_pre_count", 32'(count_a), 32'h0005);
    pause_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("pz%0d_count", k), 32'(count_a), 32'h0005);
      chk($sformatf("pz%0d_running", k), 32'(running_a), 32'h0);
    end
    pause_a = 1'b0;
    step();
    chk("pz_resume_running", 32'(running_a), 32'h1);
    chk("pz_resume_count", 32'(count_a), 32'h0005);
    step();
    chk("pz_p3_count", 32'(count_a), 32'h0005);
    step();
    chk("pz_tick_count", 32'(count_a), 32'h0004);
    step();
    chk("pz_next_count", 32'(count_a), 32'h0004);

    // Borrow chain with a tick every cycle.
    load_b = 1'b1; data_b = 16'h1000;
    step();
    load_b = 1'b0; start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("br_start_count", 32'(count_b), 32'h1000);
    chk("br_start_running", 32'(running_b), 32'h1);
    step();
    chk("br_0999", 32'(count_b), 32'h0999);
    step();
    chk("br_0998", 32'(count_b), 32'h0998);
    step();
    chk("br_0997", 32'(count_b), 32'h0997);
    load_b = 1'b1; data_b = 16'h0100;
    step();
    load_b = 1'b0; start_b = 1'b1;
    step();
    start_b = 1'b0;
    step();
    chk("br_0099", 32'(count_b), 32'h0099);
    step();
    chk("br_0098", 32'(count_b), 32'h0098);
    load_b = 1'b1; data_b = 16'h0002;
    step();
    load_b = 1'b0; start_b = 1'b1;
    step();
    start_b = 1'b0;
    step();
    chk("br_0001", 32'(count_b), 32'h0001);
    step();
    chk("br_zero", 32'(count_b), 32'h0000);
    chk("br_done", 32'(done_b), 32'h1);
    step();
    chk("br_hold_zero", 32'(count_b), 32'h0000);
    chk("br_done_once", 32'(done_b), 32'h0);

    // Asynchronous reset mid-run.
    load_a = 1'b1; data_a = 16'h0042;
    step();
    load_a = 1'b0; start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    chk("ar_pre_count", 32'(count_a), 32'h0042);
    chk("ar_pre_running", 32'(running_a), 32'h1);
    #2;
    clear_ = 1'b0;
    #1;
    chk("ar_count", 32'(count_a), 32'h0);
    chk("ar_running", 32'(running_a), 32'h0);
    chk("ar_done", 32'(done_a), 32'h0);
    chk("ar_err", 32'(err_a), 32'h0);
    #1;
    clear_ = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("ar_idle%0d_count", k), 32'(count_a), 32'h0);
      chk($sformatf("ar_idle%0d_running", k), 32'(running_a), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
Multi-digit BCD countdown timer. It is the decrementing counterpart of the team's BCD up-counter chain.
- Loads a packed BCD preset and decrements it once per prescaled tick.
- Borrows ripple across digits.
- Pulses done when zero is reached.

It sits between the board switches/keys and the seven-segment display path, feeding packed BCD digits to the display decoders.

Parameters:
- DIGITS, 4, number of BCD digits; count width is 4*DIGITS.
- PRESCALE, 50000, clk cycles per decrement tick; legal range 1..2^20; tick every cycle when 1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clear_  in  1  asynchronous active-low reset.
- load  in  1  synchronous load of data into count.
- data  in  4*DIGITS  packed BCD preset; digit 0 in bits [3:0].
- start  in  1  begin counting; honoured in IDLE only.
- pause  in  1  level; holds the count while high in RUN/PAUSED.
- count  out  4*DIGITS  current packed BCD value.
- running  out  1  high in RUN state.
- done  out  1  one-cycle pulse on expiry.
- err  out  1  sticky invalid-preset flag.

Behaviour:
- Reset (clear_ low, asynchronous):
  - state=IDLE, count=0, prescaler=0.
  - running=0, done=0, err=0.
  - Effective immediately, including mid-count.
- States: IDLE, RUN, PAUSED, EXPIRED. All outputs are registered.
- Load (priority over every other input, any state):
  - If every data nibble <= 9: count<=data, err<=0.
  - Otherwise count is unchanged and err<=1.
  - In both cases: state<=IDLE, prescaler<=0, done<=0.
  - load+start in the same cycle: load wins, start is dropped.
- IDLE:
  - start with count!=0 -> RUN, prescaler<=0.
  - start with count==0 -> EXPIRED, done pulses next cycle.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps to 0.
  - The cycle where prescaler==PRESCALE-1 is a tick.
  - On a tick, count is decremented in BCD:
    - Digit 0: if 0 it becomes 9 and borrows to digit 1; else it decrements by 1.
    - The borrow ripples upward; a digit without an incoming borrow is unchanged.
    - All digits update on the same edge.
  - A tick that takes count from 1 to 0: state->EXPIRED, done=1 for exactly that next cycle.
- Pause:
  - RUN with pause=1 -> PAUSED. The prescaler and count freeze.
  - pause=1 takes precedence over a tick in the same cycle.
  - PAUSED with pause=0 -> RUN. The prescaler resumes from its frozen value with no restart.
  - pause has no effect in IDLE or EXPIRED.
- EXPIRED:
  - count holds 0. start is ignored. Only load or reset leaves this state.
- Output flags:
  - running=1 only in RUN; it is 0 in PAUSED.
  - done is never high for more than 1 consecutive cycle.
- Count never underflows: the 0 -> 99..9 wrap cannot occur.
- Prescaler width is clog2(PRESCALE), minimum 1 bit.

Test Plan:
1. DIGITS=4, PRESCALE=4. Reset, load data=16'h0012, start. Required:
   - running=1 the cycle after start.
   - count 0012->0011->0010->0009 on each 4th cycle.
   - Reaches 0000 after 48 cycles.
   - done high for exactly 1 cycle, then EXPIRED with count=0000.
2. Borrow chain: load 16'h1000, start, PRESCALE=1. Required: next value 0999, then 0998; no invalid nibble ever appears.
3. Invalid preset: load 16'h00A5. Required:
   - err=1, count unchanged.
   - A following load 16'h0005 gives err=0, count=0005.
4. Pause: PRESCALE=4, count 0005 in RUN, pause high for 10 cycles mid-period. Required:
   - count frozen and running=0 while paused.
   - After release, the next decrement occurs after the remaining prescaler cycles only.
5. Simultaneous and zero cases:
   - load 0003 and start asserted in the same cycle -> IDLE, count=0003, no counting.
   - start with count=0000 -> done pulse next cycle, state EXPIRED.
6. Reset mid-run: clear_ low asynchronously while count=0042 in RUN. Required:
   - count=0000, running=0, done=0, err=0 before the next clk edge.
   - Stays IDLE after release.
